// File: rtl/sub_pix_pkg.sv
// Shared types and defaults for the sub-pixel delay line sequencer.
// The cfg struct is sized with DEF_CNT_W; top and slot use that width.
package sub_pix_pkg;

    localparam int DEF_CNT_W     = 10;
    localparam int DEF_MAX_STEPS = 32;
    localparam int DEF_PIPE_LAT  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0]           fract_steps;
        logic                 shift_dir;
        logic [DEF_CNT_W-1:0] num_groups;
    } cfg_t;

    function automatic logic cfg_legal(input cfg_t c, input int unsigned max_steps);
        return (32'(c.fract_steps) < max_steps) && (c.num_groups != '0);
    endfunction

endpackage

// File: rtl/sub_pix_delay_ctrl_if.sv
// Config, upstream and datapath-facing signals of the line sequencer.
// Handshakes: a transfer happens on a cycle where valid && ready; valid may not depend on ready.
interface sub_pix_delay_ctrl_if
    import sub_pix_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [7:0]       cfg_fract_steps;
    logic             cfg_shift_dir;
    logic [CNT_W-1:0] cfg_num_groups;
    logic             up_valid;
    logic             up_ready;
    logic             dp_sample_in_v;
    logic [CNT_W-1:0] dp_clk_cnt;
    logic [7:0]       dp_fract_steps;
    logic             dp_shift_dir;
    logic             dp_flush;
    logic             line_done;
    logic             busy;
    logic             err_cfg;
    state_t           dbg_state;

    modport master (
        output cfg_valid, cfg_fract_steps, cfg_shift_dir, cfg_num_groups, up_valid,
        input  cfg_ready, up_ready, dp_sample_in_v, dp_clk_cnt, dp_fract_steps,
        input  dp_shift_dir, dp_flush, line_done, busy, err_cfg, dbg_state
    );

    modport slave (
        input  cfg_valid, cfg_fract_steps, cfg_shift_dir, cfg_num_groups, up_valid,
        output cfg_ready, up_ready, dp_sample_in_v, dp_clk_cnt, dp_fract_steps,
        output dp_shift_dir, dp_flush, line_done, busy, err_cfg, dbg_state
    );

endinterface

// File: rtl/sub_pix_cfg_slot.sv
// One-entry config holding register with legality check.
// Illegal configs are consumed without filling the slot and raise a one-cycle error pulse.
module sub_pix_cfg_slot
    import sub_pix_pkg::*;
#(
    parameter int MAX_STEPS = DEF_MAX_STEPS
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    input  cfg_t i_cfg,
    input  logic i_clear,
    output logic o_ready,
    output logic o_full_next,
    output logic o_err,
    output cfg_t o_cfg
);

    logic r_full;
    logic r_err;
    cfg_t r_cfg;
    logic w_xfer;
    logic w_legal;

    assign w_xfer  = i_valid && !r_full;
    assign w_legal = cfg_legal(i_cfg, MAX_STEPS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
            r_err  <= 1'b0;
            r_cfg  <= '0;
        end else begin
            r_err <= w_xfer && !w_legal;
            if (i_clear) begin
                r_full <= 1'b0;
            end else if (w_xfer && w_legal) begin
                r_full <= 1'b1;
                r_cfg  <= i_cfg;
            end
        end
    end

    assign o_ready     = !r_full;
    // Lets the sequencer leave IDLE/DONE in the same cycle a legal config lands.
    assign o_full_next = r_full || (w_xfer && w_legal);
    assign o_err       = r_err;
    assign o_cfg       = r_cfg;

endmodule

// File: rtl/sub_pix_delay_ctrl.sv
// Line-level sequencer: loads a per-line shift config, gates upstream groups into
// the sub-pixel delay datapath with a group index, then drains and flags line completion.
module sub_pix_delay_ctrl
    import sub_pix_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_STEPS = DEF_MAX_STEPS,
    parameter int PIPE_LAT  = DEF_PIPE_LAT
) (
    input  logic                 clk,
    input  logic                 reset,
    sub_pix_delay_ctrl_if.slave  bus
);

    localparam int FL_W = $clog2(PIPE_LAT + 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_num_groups;
    logic             r_last;
    logic [7:0]       r_fract;
    logic             r_dir;
    logic             r_sample_v;
    logic [CNT_W-1:0] r_clk_cnt;
    logic             r_flush;
    logic [FL_W-1:0]  r_fl_cnt;
    logic             r_done;
    logic             r_busy;

    cfg_t             w_cfg_in;
    cfg_t             w_slot;
    logic             w_full_next;
    logic             w_clear;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cfg_in  = {bus.cfg_fract_steps, bus.cfg_shift_dir, bus.cfg_num_groups};
    assign w_clear   = (r_state == LOAD);
    assign w_cnt_inc = r_cnt + 1'b1;

    sub_pix_cfg_slot #(.MAX_STEPS(MAX_STEPS)) u_slot (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_valid     (bus.cfg_valid),
        .i_cfg       (w_cfg_in),
        .i_clear     (w_clear),
        .o_ready     (bus.cfg_ready),
        .o_full_next (w_full_next),
        .o_err       (bus.err_cfg),
        .o_cfg       (w_slot)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_num_groups <= '0;
            r_last       <= 1'b0;
            r_fract      <= '0;
            r_dir        <= 1'b0;
            r_sample_v   <= 1'b0;
            r_clk_cnt    <= '0;
            r_flush      <= 1'b0;
            r_fl_cnt     <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_sample_v <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_full_next) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_fract      <= w_slot.fract_steps;
                    r_dir        <= w_slot.shift_dir;
                    r_num_groups <= w_slot.num_groups;
                    r_cnt        <= '0;
                    r_last       <= (w_slot.num_groups == CNT_W'(1));
                    r_state      <= RUN;
                end
                RUN: begin
                    if (bus.up_valid) begin
                        r_sample_v <= 1'b1;
                        r_clk_cnt  <= r_cnt;
                        if (r_last) begin
                            r_state  <= FLUSH;
                            r_fl_cnt <= '0;
                        end else begin
                            r_cnt  <= w_cnt_inc;
                            r_last <= (w_cnt_inc == r_num_groups - 1'b1);
                        end
                    end
                end
                // First FLUSH cycle carries the last group's valid; dp_flush follows for PIPE_LAT cycles.
                FLUSH: begin
                    if (r_fl_cnt == FL_W'(PIPE_LAT)) begin
                        r_state <= DONE;
                        r_flush <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_flush  <= 1'b1;
                        r_fl_cnt <= r_fl_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (w_full_next) begin
                        r_state <= LOAD;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.up_ready       = (r_state == RUN);
    assign bus.dp_sample_in_v = r_sample_v;
    assign bus.dp_clk_cnt     = r_clk_cnt;
    assign bus.dp_fract_steps = r_fract;
    assign bus.dp_shift_dir   = r_dir;
    assign bus.dp_flush       = r_flush;
    assign bus.line_done      = r_done;
    assign bus.busy           = r_busy;
    assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_sub_pix_delay_ctrl.sv
// Directed bench for the line sequencer: driver tasks push expected datapath samples
// and line completions; a negedge monitor pops and compares them.
module tb_sub_pix_delay_ctrl;
    import sub_pix_pkg::*;

    localparam int CNT_W    = 10;
    localparam int PIPE_LAT = 4;
    localparam int W        = 8 + 1 + CNT_W;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_pix_delay_ctrl_if #(.CNT_W(CNT_W)) bus ();

    sub_pix_delay_ctrl #(.CNT_W(CNT_W), .MAX_STEPS(32), .PIPE_LAT(PIPE_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   done_q[$];

    int last_v_cyc = -1000;
    int fl_cnt     = 0;
    int done_cyc   = -1000;
    logic [CNT_W-1:0] last_cnt = '0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (reset) begin
            if (bus.dp_sample_in_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sample", int'({bus.dp_fract_steps, bus.dp_shift_dir, bus.dp_clk_cnt}), int'(e));
                    last_cnt = e[CNT_W-1:0];
                end
                last_v_cyc = cyc;
                fl_cnt     = 0;
            end else begin
                chk("clk_cnt_hold", int'(bus.dp_clk_cnt), int'(last_cnt));
            end
            if (bus.dp_flush) begin
                fl_cnt++;
                chk("flush_no_valid", int'(bus.dp_sample_in_v), 0);
            end
            if (bus.line_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("done_fract", int'(bus.dp_fract_steps), int'(done_q.pop_front()));
                    chk("done_latency", cyc - last_v_cyc, 1 + PIPE_LAT);
                    chk("flush_cycles", fl_cnt, PIPE_LAT);
                end
                done_cyc = cyc;
            end
        end else begin
            last_cnt = '0;
            fl_cnt   = 0;
        end
    end

    task automatic send_cfg(input logic [7:0] f, input logic d, input int g, output int xfer_cyc);
        int budget = 0;
        @(negedge clk);
        while (!bus.cfg_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("cfg_ready_wait", int'(bus.cfg_ready), 1);
        xfer_cyc            = cyc;
        bus.cfg_valid       = 1'b1;
        bus.cfg_fract_steps = f;
        bus.cfg_shift_dir   = d;
        bus.cfg_num_groups  = CNT_W'(g);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    // gappy selects the 1,0,0,1,1 valid pattern, repeated
    task automatic feed_line(input logic [7:0] f, input logic d, input int groups, input bit gappy,
                             output int first_rdy);
        int idx = 0;
        int k = 0;
        int budget = 0;
        bit v;
        first_rdy = -1;
        while (idx < groups && budget < groups * 6 + 50) begin
            @(negedge clk);
            budget++;
            if (!bus.up_ready) begin
                bus.up_valid = 1'b0;
            end else begin
                if (first_rdy < 0) first_rdy = cyc;
                v = gappy ? ((k % 5 == 0) || (k % 5 >= 3)) : 1'b1;
                k++;
                bus.up_valid = v;
                if (v) begin
                    exp_q.push_back({f, d, CNT_W'(idx)});
                    idx++;
                end
            end
        end
        chk("feed_groups", idx, groups);
        done_q.push_back(f);
        @(negedge clk);
        bus.up_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget = 0;
        @(negedge clk);
        while (bus.busy && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("wait_idle", int'(bus.busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int xc;
        int fr;
        int fr2;
        int budget;
        bus.cfg_valid       = 1'b0;
        bus.cfg_fract_steps = '0;
        bus.cfg_shift_dir   = 1'b0;
        bus.cfg_num_groups  = '0;
        bus.up_valid        = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
        chk("rst_up_ready", int'(bus.up_ready), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_sample_v", int'(bus.dp_sample_in_v), 0);
        chk("rst_clk_cnt", int'(bus.dp_clk_cnt), 0);
        chk("rst_fract", int'(bus.dp_fract_steps), 0);
        chk("rst_flush", int'(bus.dp_flush), 0);
        chk("rst_done", int'(bus.line_done), 0);
        chk("rst_err", int'(bus.err_cfg), 0);
        reset = 1'b1;

        // Line with continuous valid; also config-to-first-ready latency
        send_cfg(8'd5, 1'b1, 3, xc);
        feed_line(8'd5, 1'b1, 3, 1'b0, fr);
        chk("cfg_to_ready_latency", fr - xc, 2);
        wait_idle();

        // Same line with a gappy valid pattern
        send_cfg(8'd5, 1'b1, 3, xc);
        feed_line(8'd5, 1'b1, 3, 1'b1, fr);
        wait_idle();

        // Second config offered while line 1 runs; back-to-back gap
        send_cfg(8'd5, 1'b1, 3, xc);
        fork
            feed_line(8'd5, 1'b1, 3, 1'b1, fr);
            begin
                budget = 0;
                while (!bus.up_ready && budget < 50) begin
                    @(negedge clk);
                    budget++;
                end
                send_cfg(8'd31, 1'b0, 2, xc);
                chk("cfg_ready_while_full", int'(bus.cfg_ready), 0);
                chk("fract_kept_line1", int'(bus.dp_fract_steps), 5);
            end
        join
        feed_line(8'd31, 1'b0, 2, 1'b0, fr2);
        chk("b2b_gap", fr2 - done_cyc, 2);
        wait_idle();

        // Illegal configs
        send_cfg(8'd32, 1'b0, 3, xc);
        chk("err_fract_pulse", int'(bus.err_cfg), 1);
        chk("err_fract_ready", int'(bus.cfg_ready), 1);
        @(negedge clk);
        chk("err_fract_clear", int'(bus.err_cfg), 0);
        chk("err_fract_state", int'(bus.dbg_state), int'(IDLE));
        chk("err_fract_busy", int'(bus.busy), 0);
        chk("err_fract_dp", int'(bus.dp_fract_steps), 31);
        send_cfg(8'd7, 1'b1, 0, xc);
        chk("err_groups_pulse", int'(bus.err_cfg), 1);
        @(negedge clk);
        chk("err_groups_clear", int'(bus.err_cfg), 0);
        chk("err_groups_state", int'(bus.dbg_state), int'(IDLE));
        chk("err_groups_dp_fract", int'(bus.dp_fract_steps), 31);
        chk("err_groups_dp_dir", int'(bus.dp_shift_dir), 0);

        // Asynchronous reset during group 1 of a line
        send_cfg(8'd9, 1'b1, 4, xc);
        budget = 0;
        while (!bus.up_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        bus.up_valid = 1'b1;
        exp_q.push_back({8'd9, 1'b1, CNT_W'(0)});
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        bus.up_valid = 1'b0;
        #1;
        chk("arst_sample_v", int'(bus.dp_sample_in_v), 0);
        chk("arst_clk_cnt", int'(bus.dp_clk_cnt), 0);
        chk("arst_cfg_ready", int'(bus.cfg_ready), 1);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_fract", int'(bus.dp_fract_steps), 0);
        chk("arst_up_ready", int'(bus.up_ready), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send_cfg(8'd3, 1'b0, 2, xc);
        feed_line(8'd3, 1'b0, 2, 1'b0, fr);
        wait_idle();

        // Maximum group count: no wrap, no extra valid
        send_cfg(8'd17, 1'b1, 1023, xc);
        feed_line(8'd17, 1'b1, 1023, 1'b0, fr);
        wait_idle();
        chk("max_last_cnt", int'(bus.dp_clk_cnt), 1022);

        repeat (5) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sub_pix_delay_ctrl.md
Name: sub_pix_delay_ctrl

Overview:
Line-level sequencer for the 4-lane sub-pixel delay datapath. It accepts per-line shift configuration (fractional steps, direction, group count) over a valid/ready handshake and holds it stable for a whole line. It gates upstream 4-pixel groups into the datapath, generating sample_in_v and the clk_cnt group index, then drains the datapath pipeline and signals line completion. Sits between the line/config front end and the sub_pixel_delay datapath.

Parameters:
CNT_W, 10, width of group counter and dp_clk_cnt
MAX_STEPS, 32, number of legal fractional steps; legal fract_steps is 0..MAX_STEPS-1
PIPE_LAT, 4, flush cycles after the last group; covers the datapath valid-to-output latency

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration slot free
cfg_fract_steps  in  8  fractional shift steps for the next line
cfg_shift_dir  in  1  shift direction for the next line
cfg_num_groups  in  CNT_W  4-pixel groups in the next line; 0 is illegal
up_valid  in  1  upstream group present on the sample_in0..3 bus
up_ready  out  1  controller accepts the group this cycle
dp_sample_in_v  out  1  to datapath sample_in_v
dp_clk_cnt  out  CNT_W  to datapath clk_cnt; group index within the line
dp_fract_steps  out  8  to datapath fract_steps; stable for the whole line
dp_shift_dir  out  1  to datapath shift_dir; stable for the whole line
dp_flush  out  1  high during drain cycles
line_done  out  1  one-cycle pulse when a line has fully drained
busy  out  1  state != IDLE
err_cfg  out  1  one-cycle pulse when an illegal configuration is dropped

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; shadow slot empty; all outputs 0 except cfg_ready=1; active config registers and counter = 0. Reset asserted mid-line aborts the line. No line_done is issued for the aborted line.
- Shadow slot: one-entry holding register. cfg_ready = !slot_full, in every state. A transfer happens when cfg_valid && cfg_ready.
- Illegal config: cfg_fract_steps >= MAX_STEPS or cfg_num_groups == 0.
  - The transfer still completes: handshake consumed, slot stays empty.
  - err_cfg pulses on the next cycle.
- States:
  - IDLE: if slot_full -> LOAD.
  - LOAD: 1 cycle. Copy the slot into the active registers (dp_fract_steps, dp_shift_dir, num_groups). Clear the slot. Clear the counter. -> RUN.
  - RUN: up_ready = 1 until the last group has been accepted.
    - On up_valid && up_ready: next cycle dp_sample_in_v=1 and dp_clk_cnt=counter; the counter then increments.
    - Groups are accepted at 1 per cycle max. Stalls (up_valid=0) give dp_sample_in_v=0 and dp_clk_cnt holds.
    - On acceptance of group num_groups-1 -> FLUSH.
  - FLUSH: PIPE_LAT cycles. dp_flush=1, dp_sample_in_v=0, up_ready=0. -> DONE.
  - DONE: 1 cycle, line_done=1. -> LOAD if slot_full, else IDLE.
- Latency:
  - Config accepted in IDLE to first up_ready: 2 cycles (slot write, LOAD).
  - Back-to-back lines: gap of DONE+LOAD = 2 cycles with no up_ready.
- dp_fract_steps and dp_shift_dir change only in LOAD. A config accepted during RUN, FLUSH or DONE never affects the current line.
- Simultaneous events:
  - cfg transfer in the same cycle as LOAD empties the slot: not possible, because cfg_ready is registered from slot_full and the slot is full during LOAD.
  - A new config can be accepted the cycle after LOAD.
- Counter wrap: num_groups max is 2^CNT_W-1. The counter never exceeds num_groups-1.
- All outputs except up_ready and cfg_ready are registered. up_ready is decoded from state and a registered last flag.

Decomposition:
- Package sub_pix_pkg contains:
  - state enum {IDLE, LOAD, RUN, FLUSH, DONE};
  - CNT_W, MAX_STEPS, PIPE_LAT defaults;
  - a packed cfg struct {fract_steps[7:0], shift_dir, num_groups[CNT_W-1:0]}.
- Sub-module sub_pix_cfg_slot: one-deep valid/ready holding register with the legality check and the err_cfg pulse. The FSM, counter and flush timer stay in the top.

Test Plan:
- Reset, then cfg {fract=5, dir=1, groups=3}, up_valid held 1 -> dp_sample_in_v high 3 cycles with dp_clk_cnt 0,1,2; dp_flush 4 cycles; line_done pulse; dp_fract_steps=5 and dp_shift_dir=1 throughout.
- Same line with up_valid pattern 1,0,0,1,1 -> dp_clk_cnt 0,hold,hold,1,2; exactly 3 valid cycles; line_done 1+PIPE_LAT cycles after the last valid.
- Second cfg {fract=31, dir=0, groups=2} offered during RUN of line 1 -> accepted; cfg_ready=0 until LOAD; line 1 keeps fract=5; line 2 starts 2 cycles after line_done with dp_fract_steps=31.
- cfg with fract=32, and separately groups=0 -> handshake completes, err_cfg pulses once each, state stays IDLE, dp outputs unchanged.
- reset=0 asserted asynchronously at mid-RUN group 1 -> all outputs 0 and cfg_ready=1 immediately, no line_done; after release a new cfg starts cleanly from dp_clk_cnt=0.
- groups=1023 with continuous up_valid -> dp_clk_cnt reaches 1022 then FLUSH; no wrap to 0 and no extra dp_sample_in_v.
